mxv_tx_sequencer: RTL

- Downstream of the MxV control FSM; converts its one-cycle header/trailer strobes and its `transmit` phase into a strictly ordered byte stream for the UART transmitter.
- Queues header bytes (FE, length, 04) and the trailer (EF) in a small FIFO.
- Pops matrix_length results from the result FIFO and serializes each result MSB-first.
- Pulses end_tx_results when the last result byte has left the UART.

---
 rtl/mxv_tx_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mxv_tx_sequencer.sv
// mxv_tx_sequencer: orders header/trailer bytes and MSB-first result bytes onto the UART TX.
// Latency: 2 cycles from push to uart_start; waits on uart_done and res_empty, drops header pushes when full.

module mxv_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   output logic         wr_rdy,
   output logic         rd_vld,
   output logic [W-1:0] rd_dat,
   input  logic         rd_rdy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_wr;
   logic         do_rd;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign wr_rdy = !((wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]));
   assign rd_vld = (wr_ptr != rd_ptr);
   assign rd_dat = mem[rd_ptr[AW-1:0]];
   assign do_wr  = wr_vld & wr_rdy;
   assign do_rd  = rd_rdy & rd_vld;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end
endmodule

module mxv_tx_sequencer #(
   parameter int RES_W     = 16,
   parameter int RES_BYTES = RES_W / 8,
   parameter int HQ_DEPTH  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tx_en,
   input  logic [7:0]       data_in,
   input  logic             last_cmd,
   input  logic             transmit,
   input  logic [7:0]       matrix_length,
   input  logic [RES_W-1:0] res_data,
   input  logic             res_empty,
   output logic             res_pop,
   output logic [7:0]       uart_data,
   output logic             uart_start,
   input  logic             uart_done,
   output logic             end_tx_results,
   output logic             busy,
   output logic             ovf_err
);
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_Q_SEND    = 3'd1;
   localparam logic [2:0] S_RES_POP   = 3'd2;
   localparam logic [2:0] S_RES_LOAD  = 3'd3;
   localparam logic [2:0] S_RES_SEND  = 3'd4;
   localparam logic [2:0] S_WAIT_DONE = 3'd5;
   localparam logic [2:0] S_RES_NEXT  = 3'd6;
   localparam logic [2:0] S_RES_END   = 3'd7;
   localparam logic [7:0] LAST_BYTE   = 8'(RES_BYTES - 1);

   logic [2:0]       state;
   logic [2:0]       ret_r;
   logic [7:0]       len_r;
   logic [7:0]       res_cnt;
   logic [7:0]       byte_cnt;
   logic [7:0]       hold_r;
   logic [RES_W-1:0] shift_r;
   logic             res_active;
   logic             transmit_d;
   logic             transmit_rise;
   logic             q_push;
   logic [7:0]       q_push_dat;
   logic             q_ready;
   logic             q_vld;
   logic [7:0]       q_head;
   logic             q_pop;

   // tx_en outranks last_cmd when both strobe together; the trailer is lost.
   assign q_push     = tx_en | last_cmd;
   assign q_push_dat = tx_en ? data_in : 8'hEF;
   assign q_pop      = (state == S_Q_SEND);

   mxv_fifo #(.W(8), .DEPTH(HQ_DEPTH)) u_hq (
      .clk    (clk),
      .reset  (reset),
      .wr_vld (q_push),
      .wr_dat (q_push_dat),
      .wr_rdy (q_ready),
      .rd_vld (q_vld),
      .rd_dat (q_head),
      .rd_rdy (q_pop)
   );

   assign transmit_rise  = transmit & ~transmit_d;
   assign uart_start     = (state == S_Q_SEND) || (state == S_RES_SEND);
   assign res_pop        = (state == S_RES_POP);
   assign end_tx_results = (state == S_RES_END);
   assign busy           = (state != S_IDLE) || q_vld;

   always_comb begin
      uart_data = 8'h00;
      case (state)
         S_Q_SEND:    uart_data = q_head;
         S_RES_SEND:  uart_data = shift_r[RES_W-1 -: 8];
         S_WAIT_DONE: uart_data = hold_r;
         default:     uart_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         ret_r      <= S_IDLE;
         len_r      <= 8'h00;
         res_cnt    <= 8'h00;
         byte_cnt   <= 8'h00;
         hold_r     <= 8'h00;
         shift_r    <= '0;
         res_active <= 1'b0;
         transmit_d <= 1'b0;
         ovf_err    <= 1'b0;
      end else begin
         transmit_d <= transmit;
         if ((tx_en && last_cmd) || (q_push && !q_ready)) ovf_err <= 1'b1;

         case (state)
            S_IDLE: begin
               if (q_vld)                             state <= S_Q_SEND;
               else if (res_active && res_cnt == len_r) state <= S_RES_END;
               else if (res_active && !res_empty)     state <= S_RES_POP;
            end
            S_Q_SEND: begin
               hold_r <= q_head;
               ret_r  <= S_IDLE;
               state  <= S_WAIT_DONE;
            end
            S_RES_POP:  state <= S_RES_LOAD;
            S_RES_LOAD: begin
               shift_r  <= res_data;
               byte_cnt <= 8'h00;
               state    <= S_RES_SEND;
            end
            S_RES_SEND: begin
               hold_r <= shift_r[RES_W-1 -: 8];
               ret_r  <= S_RES_NEXT;
               state  <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (uart_done) state <= ret_r;
            end
            // Returning to IDLE only between words keeps a loaded word contiguous.
            S_RES_NEXT: begin
               shift_r  <= shift_r << 8;
               byte_cnt <= byte_cnt + 8'd1;
               if (byte_cnt == LAST_BYTE) begin
                  res_cnt <= res_cnt + 8'd1;
                  state   <= S_IDLE;
               end else begin
                  state   <= S_RES_SEND;
               end
            end
            S_RES_END: begin
               res_active <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (transmit_rise) begin
            len_r      <= matrix_length;
            res_cnt    <= 8'h00;
            res_active <= 1'b1;
         end
      end
   end
endmodule
